// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the writeback requesters, the arbiter and register_file.
// master: requester/register-file side (drives req*, observes ready, WE3/A3/WD3, status)
// slave : arbiter side (observes req*, drives ready, WE3/A3/WD3, busy, init_done)
interface regfile_write_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              WE3;
    logic [ADDR_W-1:0] A3;
    logic [DATA_W-1:0] WD3;
    logic              busy;
    logic              init_done;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  WE3, A3, WD3, busy, init_done
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output WE3, A3, WD3, busy, init_done
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Owner of the register file write port (WE3/A3/WD3).
// After reset it clears x1..x(2**ADDR_W-1), one per cycle, then arbitrates
// round-robin between two valid/ready writeback requesters.
// Ports:
//   CLK   - system clock, rising edge
//   RST_N - asynchronous active-low reset
//   bus   - slave side of regfile_write_arbiter_if: req0/req1 handshakes,
//           registered WE3/A3/WD3, busy (sweep running), init_done (accepting)
module regfile_write_arbiter #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 5,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    regfile_write_arbiter_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_REG = '1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;
    logic              last_grant, last_grant_next;
    logic              we_q, we_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [DATA_W-1:0] data_q, data_next;
    logic              busy_q, busy_next;
    logic              done_q, done_next;
    logic              grant0, grant1;

    // Round-robin grant; depends only on valids, state and last_grant.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ST_RUN) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Next-state and next-output logic.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        last_grant_next = last_grant;
        we_next         = 1'b0;
        addr_next       = addr_q;
        data_next       = data_q;

        if (state == ST_INIT) begin
            if (CLEAR_ON_RESET) begin
                we_next   = 1'b1;
                addr_next = cnt;
                data_next = '0;
                cnt_next  = cnt + ADDR_W'(1);
                if (cnt == LAST_REG) begin
                    state_next = ST_RUN;
                end
            end else begin
                state_next = ST_RUN;
            end
        end else begin
            // x0 is hardwired: complete the handshake but suppress the write.
            if (grant0) begin
                we_next         = |bus.req0_addr;
                addr_next       = bus.req0_addr;
                data_next       = bus.req0_data;
                last_grant_next = 1'b0;
            end else if (grant1) begin
                we_next         = |bus.req1_addr;
                addr_next       = bus.req1_addr;
                data_next       = bus.req1_data;
                last_grant_next = 1'b1;
            end
        end

        busy_next = (state_next == ST_INIT);
        done_next = (state_next == ST_RUN);
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_INIT;
            cnt        <= ADDR_W'(1);
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            last_grant <= last_grant_next;
            we_q       <= we_next;
            addr_q     <= addr_next;
            data_q     <= data_next;
            busy_q     <= busy_next;
            done_q     <= done_next;
        end
    end

    assign bus.WE3       = we_q;
    assign bus.A3        = addr_q;
    assign bus.WD3       = data_q;
    assign bus.busy      = busy_q;
    assign bus.init_done = done_q;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (WE3/A3/WD3) of the 32x32 register file.
- After reset it runs a clear sweep that writes 0 to x1..x31, one register per cycle.
- It then shares the write port between two writeback requesters with valid/ready handshakes and round-robin arbitration.
- Sits between the writeback sources (req0 = ALU/load path, req1 = multi-cycle unit) and register_file.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width (2**ADDR_W registers).
- CLEAR_ON_RESET, 1, 1 = run the clear sweep after reset; 0 = skip it.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req0_data  in  DATA_W  requester 0 write data.
- req0_ready  out  1  requester 0 is granted this cycle.
- req1_valid  in  1  requester 1 has a write pending.
- req1_addr  in  ADDR_W  requester 1 destination register.
- req1_data  in  DATA_W  requester 1 write data.
- req1_ready  out  1  requester 1 is granted this cycle.
- WE3  out  1  register file write enable (registered).
- A3  out  ADDR_W  register file write address (registered).
- WD3  out  DATA_W  register file write data (registered).
- busy  out  1  clear sweep in progress.
- init_done  out  1  sweep complete; arbiter is accepting requests.

Behaviour:
- Reset values (RST_N low, asynchronous): WE3=0, A3=0, WD3=0, req0_ready=0, req1_ready=0, busy=1, init_done=0. Internally: state=INIT, clear counter=1, last_grant=1, so req0 wins the first tie.
- FSM has two states, INIT and RUN.
- INIT: on each rising edge, load WE3=1, A3=cnt, WD3=0, then cnt++.
  - The edge that loads A3=31 moves the FSM to RUN.
  - So x1..x31 are presented on edges 1..31 after RST_N rises, and committed by register_file on edges 2..32.
  - req*_ready=0 and busy=1 throughout INIT.
  - Requests presented during INIT are ignored, not lost: requesters hold valid until they see ready.
- With CLEAR_ON_RESET=0, the first edge after reset release moves straight to RUN with WE3=0.
- RUN: busy=0, init_done=1.
- Grant rule (combinational ready, at most one ready high per cycle):
  - Only one requester valid: it gets ready.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: both ready=0.
- A ready output never depends on that requester's own addr or data.
- Transfer happens when valid && ready at a rising edge. On that edge:
  - load WE3=1, A3=addr, WD3=data of the winner;
  - last_grant becomes the winner.
- Edge with no transfer in RUN: WE3<=0; A3/WD3 hold their previous values.
- Latency: transfer at edge E, register file commits at edge E+1, data readable on RD1/RD2 after E+1. Throughput is one write per cycle.
- Address 0: the handshake completes normally, but WE3 stays 0 for that write; last_grant still updates.
- Requesters must hold valid/addr/data stable until transfer. The arbiter has no buffering beyond the single output register.
- Mid-operation reset: RST_N low at any time (during INIT or RUN) forces the reset values immediately.
  - An in-flight registered write (WE3=1) is dropped.
  - The sweep restarts from x1 after release.
- Reset release is synchronous to CLK on the upstream side; the block does not add a synchronizer.

Test Plan:
- Reset sweep: hold RST_N=0 for 2 cycles, release, preload all registers to 0xFFFFFFFF beforehand. Required: busy=1 for exactly 31 cycles, WE3=1 with A3=1..31 in order, init_done=1 on cycle 32, every register reads 0x00000000.
- Single requester: after init, req0 writes x5=0x12345678. Required: req0_ready=1 the same cycle, WE3=1/A3=5 the next cycle, RD1 with A1=5 reads 0x12345678 one cycle later.
- Contention: both valid every cycle, req0 writing x1..x4 = 1..4 and req1 writing x10..x13 = 10..13. Required: grants alternate 0,1,0,1,...; all 8 writes land; no cycle has both ready=1.
- x0 write: req1 writes x0=0x87654321. Required: req1_ready=1, WE3 stays 0, x0 still reads 0.
- Back-to-back: req0 writes x1..x31 with value = index on consecutive cycles. Required: one write per cycle, all 31 read back correctly with no gaps.
- Mid-sweep reset: pull RST_N low at cycle 10 of the sweep. Required: WE3=0 immediately; after release, A3 restarts at 1 and the full 31-cycle sweep repeats.
